huffman_code_gen: RTL and testbench

- Parametrised successor to the fixed 10-symbol Huffman code stack.
- Takes a merge list from the tree-build stage and a run-time active symbol count, then walks the tree depth-first with an internal stack, one node per cycle.
- Produces a right-aligned codeword and a code length for every symbol, and flags malformed trees.
- Sits between the Huffman tree builder and the bitstream packer.

---
 rtl/huffman_pkg.sv | 24 ++
 rtl/huffman_code_lifo.sv | 46 ++++
 rtl/huffman_code_gen.sv | 180 ++++++++++++++++++
 tb/tb_huffman_code_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared types and width helpers for the Huffman code generator and tree builder.
// Stack entries are packed as {node[IDX_W], code[MAX_LEN], len[LEN_W]}.
package huffman_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WALK = 2'd2,
    ST_DONE = 2'd3
  } code_state_t;

  function automatic int idx_width(input int n_sym);
    return $clog2(2 * n_sym - 1);
  endfunction

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int entry_width(input int idx_w, input int max_len, input int len_w);
    return idx_w + max_len + len_w;
  endfunction

endpackage

// File: rtl/huffman_code_lifo.sv
// LIFO with one pop and up to two pushes per cycle; push_b lands above push_a.
// clr discards the current contents before this cycle's pushes are applied.
module code_lifo #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 32
) (
  input  logic                           clk_sys,
  input  logic                           rst_b,
  input  logic                           clr,
  input  logic                           pop,
  input  logic                           push_a,
  input  logic                           push_b,
  input  logic [WIDTH-1:0]               data_a,
  input  logic [WIDTH-1:0]               data_b,
  output logic [WIDTH-1:0]               top,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] slot_b;

  always_comb begin
    base   = clr ? '0 : cnt_q - CNT_W'(pop && (cnt_q != '0));
    slot_b = base + CNT_W'(push_a);
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= slot_b + CNT_W'(push_b);
  end

  always_ff @(posedge clk_sys) begin
    if (push_a) mem[PTR_W'(base)]   <= data_a;
    if (push_b) mem[PTR_W'(slot_b)] <= data_b;
  end

  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign top   = empty ? '0 : mem[PTR_W'(cnt_q - CNT_W'(1))];

endmodule

// File: rtl/huffman_code_gen.sv
// Walks a Huffman merge list depth-first, one node per cycle, emitting codes/lengths.
// state | meaning
// IDLE  | waiting for Start_code
// LOAD  | latch inputs, clear results, push root
// WALK  | pop one node; leaf -> write code, internal -> push both children
// DONE  | one-cycle Done pulse, then IDLE
module huffman_code_gen
  import huffman_pkg::*;
#(
  parameter int N_SYM   = 10,
  parameter int MAX_LEN = 13,
  parameter int IDX_W   = idx_width(N_SYM),
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic                         Clk_in,
  input  logic                         n_Rst,
  input  logic                         Start_code,
  input  logic [IDX_W-1:0]             Num_sym,
  input  logic [(N_SYM-1)*2*IDX_W-1:0] Merge_in,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Err,
  output logic [N_SYM*MAX_LEN-1:0]     Code_out,
  output logic [N_SYM*LEN_W-1:0]       Len_out
);
  localparam int ENT_W = entry_width(IDX_W, MAX_LEN, LEN_W);
  localparam int DEPTH = MAX_LEN + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int N_MRG = N_SYM - 1;
  localparam int MRG_W = (N_MRG > 1) ? $clog2(N_MRG) : 1;
  localparam int SYM_W = $clog2(N_SYM);

  code_state_t state_q, state_d;
  logic [(N_SYM-1)*2*IDX_W-1:0] merge_q;
  logic [IDX_W-1:0]   num_q;
  logic [MAX_LEN-1:0] code_q [N_SYM];
  logic [LEN_W-1:0]   len_q  [N_SYM];
  logic [N_SYM-1:0]   visited_q;
  logic               err_q;

  logic [2*IDX_W-1:0] merge_arr [N_MRG];
  logic               lifo_clr, lifo_pop, push_a, push_b, lifo_empty;
  logic [ENT_W-1:0]   data_a, data_b, lifo_top;
  logic [CNT_W-1:0]   lifo_cnt;
  logic               set_err, wr_leaf, is_leaf;

  logic [IDX_W-1:0]   top_node, k_full, left_idx, right_idx, root_idx;
  logic [MAX_LEN-1:0] top_code;
  logic [LEN_W-1:0]   top_len, len_inc;
  logic [SYM_W-1:0]   leaf_sel;
  logic [MRG_W-1:0]   mrg_sel;
  logic [2*IDX_W-1:0] mrg;

  for (genvar k = 0; k < N_MRG; k++) begin : g_merge
    assign merge_arr[k] = merge_q[k*2*IDX_W +: 2*IDX_W];
  end

  for (genvar s = 0; s < N_SYM; s++) begin : g_out
    assign Code_out[s*MAX_LEN +: MAX_LEN] = code_q[s];
    assign Len_out[s*LEN_W +: LEN_W]      = len_q[s];
  end

  assign top_node  = lifo_top[ENT_W-1 -: IDX_W];
  assign top_code  = lifo_top[LEN_W +: MAX_LEN];
  assign top_len   = lifo_top[LEN_W-1:0];
  assign len_inc   = top_len + LEN_W'(1);
  assign is_leaf   = int'(top_node) < N_SYM;
  assign leaf_sel  = is_leaf ? SYM_W'(top_node) : '0;
  assign k_full    = top_node - IDX_W'(N_SYM);
  assign mrg_sel   = (int'(k_full) < N_MRG) ? MRG_W'(k_full) : '0;
  assign mrg       = merge_arr[mrg_sel];
  assign left_idx  = mrg[2*IDX_W-1 -: IDX_W];
  assign right_idx = mrg[IDX_W-1:0];
  assign root_idx  = IDX_W'(N_SYM + int'(Num_sym) - 2);

  always_comb begin
    state_d  = state_q;
    lifo_clr = 1'b0;
    lifo_pop = 1'b0;
    push_a   = 1'b0;
    push_b   = 1'b0;
    data_a   = '0;
    data_b   = '0;
    set_err  = 1'b0;
    wr_leaf  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (Start_code) state_d = ST_LOAD;
      ST_LOAD: begin
        lifo_clr = 1'b1;
        if (Num_sym == '0 || int'(Num_sym) > N_SYM) begin
          set_err = 1'b1;
          state_d = ST_DONE;
        end else begin
          push_b  = 1'b1;
          data_b  = (Num_sym == IDX_W'(1)) ? {IDX_W'(0), MAX_LEN'(0), LEN_W'(1)}
                                           : {root_idx, MAX_LEN'(0), LEN_W'(0)};
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        lifo_pop = 1'b1;
        if (lifo_empty) begin
          state_d = ST_DONE;
        end else if (is_leaf) begin
          if (int'(top_node) >= int'(num_q) || visited_q[leaf_sel]) begin
            set_err = 1'b1;
            state_d = ST_DONE;
          end else begin
            wr_leaf = 1'b1;
            if (lifo_cnt == CNT_W'(1)) state_d = ST_DONE;
          end
        end else if (int'(k_full) > int'(num_q) - 2 || int'(left_idx) >= int'(top_node) ||
                     int'(right_idx) >= int'(top_node) || top_len == LEN_W'(MAX_LEN)) begin
          // children must have lower indices than their parent, which rules out cycles
          set_err = 1'b1;
          state_d = ST_DONE;
        end else begin
          push_a = 1'b1;
          push_b = 1'b1;
          data_a = {right_idx, top_code[MAX_LEN-2:0], 1'b1, len_inc};
          data_b = {left_idx,  top_code[MAX_LEN-2:0], 1'b0, len_inc};
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      state_q   <= ST_IDLE;
      merge_q   <= '0;
      num_q     <= '0;
      visited_q <= '0;
      err_q     <= 1'b0;
      for (int s = 0; s < N_SYM; s++) begin
        code_q[s] <= '0;
        len_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == ST_LOAD) begin
        merge_q   <= Merge_in;
        num_q     <= Num_sym;
        visited_q <= '0;
        err_q     <= set_err;
        for (int s = 0; s < N_SYM; s++) begin
          code_q[s] <= '0;
          len_q[s]  <= '0;
        end
      end else begin
        if (set_err) err_q <= 1'b1;
        if (wr_leaf) begin
          code_q[leaf_sel]    <= top_code;
          len_q[leaf_sel]     <= top_len;
          visited_q[leaf_sel] <= 1'b1;
        end
      end
    end
  end

  code_lifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_lifo (
    .clk_sys (Clk_in),
    .rst_b   (n_Rst),
    .clr     (lifo_clr),
    .pop     (lifo_pop),
    .push_a  (push_a),
    .push_b  (push_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .top     (lifo_top),
    .empty   (lifo_empty),
    .count   (lifo_cnt)
  );

  assign Busy = (state_q == ST_LOAD) || (state_q == ST_WALK);
  assign Done = (state_q == ST_DONE);
  assign Err  = err_q;

endmodule

// File: tb/tb_huffman_code_gen.sv
// Directed bench for huffman_code_gen: default instance plus a MAX_LEN=8 instance
// sharing the same stimulus, used for the depth-limit case.
module tb_huffman_code_gen;
  localparam int N_SYM = 10;
  localparam int MAX_LEN = 13;
  localparam int MAX8 = 8;
  localparam int IDX_W = 5;
  localparam int LEN_W = 4;
  localparam int MW = (N_SYM - 1) * 2 * IDX_W;
  localparam int CW = N_SYM * MAX_LEN;
  localparam int LW = N_SYM * LEN_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [IDX_W-1:0] num_sym = '0;
  logic [MW-1:0] merge = '0;
  logic busy, done, err, busy8, done8, err8;
  logic [CW-1:0] code;
  logic [LW-1:0] len;
  logic [N_SYM*MAX8-1:0] code8;
  logic [LW-1:0] len8;

  int total = 0;
  int bad = 0;
  int cyc13, cyc8, dpulse13, dpulse8, quiet_done;
  logic busy_bad;

  always #5 clk = ~clk;

  huffman_code_gen u_dut (
    .Clk_in(clk), .n_Rst(rst_n), .Start_code(start), .Num_sym(num_sym), .Merge_in(merge),
    .Busy(busy), .Done(done), .Err(err), .Code_out(code), .Len_out(len)
  );

  huffman_code_gen #(.N_SYM(N_SYM), .MAX_LEN(MAX8)) u_dut8 (
    .Clk_in(clk), .n_Rst(rst_n), .Start_code(start), .Num_sym(num_sym), .Merge_in(merge),
    .Busy(busy8), .Done(done8), .Err(err8), .Code_out(code8), .Len_out(len8)
  );

  typedef struct {
    logic [IDX_W-1:0] num;
    logic [MW-1:0]    merge;
    int               cyc;
    logic             err;
    logic [CW-1:0]    code;
    logic [LW-1:0]    len;
  } vec_t;

  vec_t cur;
  vec_t vq[$];

  function automatic logic [MW-1:0] mg(input logic [MW-1:0] m, input int k, input int l, input int r);
    logic [MW-1:0] t = m;
    t[k*2*IDX_W +: 2*IDX_W] = {IDX_W'(l), IDX_W'(r)};
    return t;
  endfunction

  task automatic begin_vec(input int n, input int cyc, input logic e);
    cur.num = IDX_W'(n);
    cur.merge = '0;
    cur.cyc = cyc;
    cur.err = e;
    cur.code = '0;
    cur.len = '0;
  endtask

  task automatic sym(input int s, input int c, input int l);
    cur.code[s*MAX_LEN +: MAX_LEN] = MAX_LEN'(c);
    cur.len[s*LEN_W +: LEN_W] = LEN_W'(l);
  endtask

  task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int restart_at);
    cyc13 = -1; cyc8 = -1; dpulse13 = 0; dpulse8 = 0; busy_bad = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    if (!busy) busy_bad = 1'b1;
    for (int i = 1; i <= 60 && !(cyc13 >= 0 && cyc8 >= 0); i++) begin
      start = (i == restart_at);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin dpulse13++; if (cyc13 < 0) cyc13 = i; if (busy) busy_bad = 1'b1; end
      if (done8) begin dpulse8++; if (cyc8 < 0) cyc8 = i; end
      if (cyc13 < 0 && !busy) busy_bad = 1'b1;
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dpulse13++;
      if (done8) dpulse8++;
    end
  endtask

  task automatic apply_cur();
    @(negedge clk);
    num_sym = cur.num;
    merge = cur.merge;
  endtask

  task automatic set_num4();
    begin_vec(4, 8, 1'b0);
    cur.merge = mg(cur.merge, 0, 2, 3);
    cur.merge = mg(cur.merge, 1, 1, 10);
    cur.merge = mg(cur.merge, 2, 0, 11);
    sym(0, 0, 1); sym(1, 2, 2); sym(2, 6, 3); sym(3, 7, 3);
  endtask

  task automatic set_skew();
    begin_vec(10, 20, 1'b0);
    cur.merge = mg(cur.merge, 0, 1, 0);
    for (int j = 1; j <= 8; j++) cur.merge = mg(cur.merge, j, j + 1, 9 + j);
    for (int k = 2; k <= 9; k++) sym(k, (1 << (10 - k)) - 2, 10 - k);
    sym(1, 510, 9);
    sym(0, 511, 9);
  endtask

  initial begin
    // table of whole-run vectors
    set_num4(); vq.push_back(cur);
    begin_vec(1, 2, 1'b0); sym(0, 0, 1); vq.push_back(cur);
    begin_vec(8, 16, 1'b0);
    cur.merge = mg(cur.merge, 0, 0, 1);   cur.merge = mg(cur.merge, 1, 2, 3);
    cur.merge = mg(cur.merge, 2, 4, 5);   cur.merge = mg(cur.merge, 3, 6, 7);
    cur.merge = mg(cur.merge, 4, 10, 11); cur.merge = mg(cur.merge, 5, 12, 13);
    cur.merge = mg(cur.merge, 6, 14, 15);
    for (int s = 0; s < 8; s++) sym(s, s, 3);
    vq.push_back(cur);
    set_skew(); vq.push_back(cur);
    begin_vec(4, 4, 1'b1);
    cur.merge = mg(cur.merge, 0, 0, 1); cur.merge = mg(cur.merge, 1, 11, 3);
    cur.merge = mg(cur.merge, 2, 2, 11);
    sym(2, 0, 1);
    vq.push_back(cur);
    begin_vec(4, 7, 1'b1);
    cur.merge = mg(cur.merge, 0, 2, 3); cur.merge = mg(cur.merge, 1, 2, 10);
    cur.merge = mg(cur.merge, 2, 0, 11);
    sym(0, 0, 1); sym(2, 2, 2);
    vq.push_back(cur);
    begin_vec(0, 1, 1'b1); vq.push_back(cur);
    begin_vec(3, 3, 1'b1);
    cur.merge = mg(cur.merge, 0, 0, 1); cur.merge = mg(cur.merge, 1, 5, 10);
    vq.push_back(cur);
    begin_vec(11, 1, 1'b1); vq.push_back(cur);

    // reset state
    #22;
    check("rst_flags", CW'({busy, done, err, busy8, done8, err8}), CW'(0));
    check("rst_code", code, CW'(0));
    check("rst_len", CW'(len), CW'(0));
    @(negedge clk); rst_n = 1'b1;

    foreach (vq[i]) begin
      cur = vq[i];
      apply_cur();
      run(0);
      check($sformatf("v%0d_code", i), code, cur.code);
      check($sformatf("v%0d_len", i), CW'(len), CW'(cur.len));
      check($sformatf("v%0d_err", i), CW'(err), CW'(cur.err));
      check($sformatf("v%0d_done_cyc", i), CW'(cyc13), CW'(cur.cyc));
      check($sformatf("v%0d_done_pulses", i), CW'(dpulse13), CW'(1));
      check($sformatf("v%0d_busy_shape", i), CW'(busy_bad), CW'(0));
    end

    // depth limit: MAX_LEN=8 instance hits len==8 at node 10 on pop 17
    set_skew();
    apply_cur();
    run(0);
    check("skew8_err", CW'(err8), CW'(1));
    check("skew8_done_cyc", CW'(cyc8), CW'(18));
    check("skew8_done_pulses", CW'(dpulse8), CW'(1));
    begin
      logic [LW-1:0] el = '0;
      logic [N_SYM*MAX8-1:0] ec = '0;
      for (int k = 2; k <= 9; k++) begin
        el[k*LEN_W +: LEN_W] = LEN_W'(10 - k);
        ec[k*MAX8 +: MAX8] = MAX8'((1 << (10 - k)) - 2);
      end
      check("skew8_len", CW'(len8), CW'(el));
      check("skew8_code", CW'(code8), CW'(ec));
    end

    // Start_code re-asserted during WALK is ignored
    set_num4();
    apply_cur();
    run(3);
    check("restart_code", code, cur.code);
    check("restart_len", CW'(len), CW'(cur.len));
    check("restart_done_cyc", CW'(cyc13), CW'(8));
    check("restart_done_pulses", CW'(dpulse13), CW'(1));

    // reset in the middle of a walk
    begin_vec(8, 16, 1'b0);
    cur = vq[2];
    apply_cur();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", CW'({busy, done, err}), CW'(0));
    check("midrst_code", code, CW'(0));
    check("midrst_len", CW'(len), CW'(0));
    @(negedge clk); rst_n = 1'b1;
    quiet_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) quiet_done++;
    end
    check("midrst_no_done", CW'(quiet_done), CW'(0));
    set_num4();
    apply_cur();
    run(0);
    check("postrst_code", code, cur.code);
    check("postrst_len", CW'(len), CW'(cur.len));
    check("postrst_done_cyc", CW'(cyc13), CW'(8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
